// File: rtl/ce_window_gen.sv
// Sliding-window generator feeding the convolution engine: buffers KERNEL-1 lines
// and emits every fully-inside KERNEL x KERNEL x CL_IN window, packed for data2conv.
module ce_window_gen #(
    parameter int CL_IN  = 4,
    parameter int KERNEL = 3,
    parameter int N      = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CL_IN*N-1:0]               pix_in,
    input  logic                             en_in,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
    output logic                             en_out,
    output logic                             frame_done
);
    localparam int PW = CL_IN * N;
    localparam int WW = CL_IN * KERNEL * KERNEL * N;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] win_q   [KERNEL][KERNEL];
    logic [PW-1:0] win_d   [KERNEL][KERNEL];
    logic [PW-1:0] col_new [KERNEL];
    logic [WW-1:0] pack_d;
    logic [WW-1:0] data_q;
    logic          vld_d;
    logic          last_d;
    logic          en_out_q;
    logic          frame_done_q;

    generate
        if (KERNEL > 1) begin : g_lb
            // Entry 0 is the newest pixel; entry IMG_W-1 is the same column one line earlier.
            logic [PW-1:0] lb_q [KERNEL-1][IMG_W];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int j = 0; j < KERNEL-1; j++)
                        for (int x = 0; x < IMG_W; x++)
                            lb_q[j][x] <= '0;
                end else if (en_in) begin
                    lb_q[0][0] <= pix_in;
                    for (int j = 1; j < KERNEL-1; j++)
                        lb_q[j][0] <= lb_q[j-1][IMG_W-1];
                    for (int j = 0; j < KERNEL-1; j++)
                        for (int x = 1; x < IMG_W; x++)
                            lb_q[j][x] <= lb_q[j][x-1];
                end
            end

            for (genvar r = 0; r < KERNEL-1; r++) begin : g_col
                assign col_new[r] = lb_q[KERNEL-2-r][IMG_W-1];
            end
        end
    endgenerate

    assign col_new[KERNEL-1] = pix_in;

    always_comb begin
        pack_d = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int k = 0; k < KERNEL-1; k++)
                win_d[r][k] = win_q[r][k+1];
            win_d[r][KERNEL-1] = col_new[r];
        end
        for (int c = 0; c < CL_IN; c++)
            for (int r = 0; r < KERNEL; r++)
                for (int k = 0; k < KERNEL; k++)
                    pack_d[(c*KERNEL*KERNEL + r*KERNEL + k)*N +: N] = win_d[r][k][c*N +: N];
    end

    // Validity comes from the raster position, never from window contents.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        vld_d  = en_in && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
        if (en_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            data_q       <= '0;
            en_out_q     <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < KERNEL; r++)
                for (int k = 0; k < KERNEL; k++)
                    win_q[r][k] <= '0;
        end else begin
            en_out_q     <= vld_d;
            frame_done_q <= en_in && last_d;
            if (vld_d)
                data_q <= pack_d;
            if (en_in) begin
                col_q <= col_d;
                row_q <= row_d;
                for (int r = 0; r < KERNEL; r++)
                    for (int k = 0; k < KERNEL; k++)
                        win_q[r][k] <= win_d[r][k];
            end
        end
    end

    assign data2conv  = data_q;
    assign en_out     = en_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ce_window_gen.sv
// Directed bench for ce_window_gen: 3x3 windows on a 5x4 image (1 and 2 channels)
// plus a KERNEL=1 pass-through instance, checked against hand-computed tables.
module tb_ce_window_gen;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en_ab = 1'b0;
    logic [7:0]   pix_a = '0;
    logic [15:0]  pix_b = '0;
    logic [71:0]  d_a;
    logic [143:0] d_b;
    logic         eo_a, fd_a, eo_b, fd_b;
    logic         en_c = 1'b0;
    logic [7:0]   pix_c = '0;
    logic [7:0]   d_c;
    logic         eo_c, fd_c;

    always #5 clk = ~clk;

    ce_window_gen #(.CL_IN(1), .KERNEL(3), .N(8), .IMG_W(5), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst), .pix_in(pix_a), .en_in(en_ab),
        .data2conv(d_a), .en_out(eo_a), .frame_done(fd_a));

    ce_window_gen #(.CL_IN(2), .KERNEL(3), .N(8), .IMG_W(5), .IMG_H(4)) u_b (
        .clk(clk), .rst(rst), .pix_in(pix_b), .en_in(en_ab),
        .data2conv(d_b), .en_out(eo_b), .frame_done(fd_b));

    ce_window_gen #(.CL_IN(1), .KERNEL(1), .N(8), .IMG_W(2), .IMG_H(2)) u_c (
        .clk(clk), .rst(rst), .pix_in(pix_c), .en_in(en_c),
        .data2conv(d_c), .en_out(eo_c), .frame_done(fd_c));

    typedef struct {
        logic [71:0] win;
        logic        fd;
    } win_t;

    typedef struct {
        logic       en;
        logic [7:0] pix;
        logic       exp_en;
        logic [7:0] exp_d;
        logic       exp_fd;
    } k1_t;

    win_t wtab [6];
    k1_t  ktab [7];

    int n_checks = 0;
    int n_err    = 0;
    int mrow, mcol, widx, n_win, n_fd;
    logic [71:0]  last_a;
    logic [143:0] last_b;

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic beat_ab(input logic en, input logic [7:0] p);
        logic       ev;
        logic       efd;
        logic [71:0] ew;
        @(negedge clk);
        en_ab = en;
        pix_a = p;
        pix_b = {p | 8'h80, p};
        ev  = en && (mrow >= 2) && (mcol >= 2);
        efd = 1'b0;
        if (ev) begin
            ew     = wtab[widx % 6].win;
            efd    = wtab[widx % 6].fd;
            last_a = ew;
            last_b = {ew | {9{8'h80}}, ew};
            widx++;
        end
        @(posedge clk);
        #1;
        chk("en_out_a", 144'(eo_a), 144'(ev));
        chk("en_out_b", 144'(eo_b), 144'(ev));
        chk("frame_done_a", 144'(fd_a), 144'(efd));
        chk("frame_done_b", 144'(fd_b), 144'(efd));
        chk("data_a", 144'(d_a), 144'(last_a));
        chk("data_b", d_b, last_b);
        if (eo_a) n_win++;
        if (fd_a) n_fd++;
        if (en) begin
            if (mcol == 4) begin
                mcol = 0;
                mrow = (mrow == 3) ? 0 : mrow + 1;
            end else begin
                mcol++;
            end
        end
    endtask

    task automatic frame_ab(input logic gaps);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                beat_ab(1'b1, 8'(r*16 + c));
                if (gaps) beat_ab(1'b0, 8'hEE);
            end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst   = 1'b0;
        en_ab = 1'b1;
        pix_a = 8'h77;
        pix_b = 16'h7777;
        en_c  = 1'b1;
        pix_c = 8'h99;
        @(posedge clk);
        #1;
        chk("rst_en_out_a", 144'(eo_a), 144'd0);
        chk("rst_data_a", 144'(d_a), 144'd0);
        chk("rst_frame_done_a", 144'(fd_a), 144'd0);
        chk("rst_data_b", d_b, 144'd0);
        chk("rst_en_out_c", 144'(eo_c), 144'd0);
        chk("rst_data_c", 144'(d_c), 144'd0);
        @(negedge clk);
        rst    = 1'b1;
        en_ab  = 1'b0;
        en_c   = 1'b0;
        mrow   = 0;
        mcol   = 0;
        widx   = 0;
        last_a = '0;
        last_b = '0;
    endtask

    initial begin
        // Element 0 sits in the low byte: window top-left is the rightmost byte.
        wtab[0] = '{72'h22_21_20_12_11_10_02_01_00, 1'b0};
        wtab[1] = '{72'h23_22_21_13_12_11_03_02_01, 1'b0};
        wtab[2] = '{72'h24_23_22_14_13_12_04_03_02, 1'b0};
        wtab[3] = '{72'h32_31_30_22_21_20_12_11_10, 1'b0};
        wtab[4] = '{72'h33_32_31_23_22_21_13_12_11, 1'b0};
        wtab[5] = '{72'h34_33_32_24_23_22_14_13_12, 1'b1};

        ktab[0] = '{1'b1, 8'hA1, 1'b1, 8'hA1, 1'b0};
        ktab[1] = '{1'b0, 8'hFF, 1'b0, 8'hA1, 1'b0};
        ktab[2] = '{1'b1, 8'hB2, 1'b1, 8'hB2, 1'b0};
        ktab[3] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b0};
        ktab[4] = '{1'b1, 8'hD4, 1'b1, 8'hD4, 1'b1};
        ktab[5] = '{1'b1, 8'hE5, 1'b1, 8'hE5, 1'b0};
        ktab[6] = '{1'b0, 8'h00, 1'b0, 8'hE5, 1'b0};

        do_reset();

        // Continuous frame
        n_win = 0;
        n_fd  = 0;
        frame_ab(1'b0);
        chk("s1_windows", 144'(n_win), 144'd6);
        chk("s1_frame_done", 144'(n_fd), 144'd1);

        // Same frame with a bubble after every pixel
        n_win = 0;
        n_fd  = 0;
        frame_ab(1'b1);
        chk("s2_windows", 144'(n_win), 144'd6);
        chk("s2_frame_done", 144'(n_fd), 144'd1);

        // Partial frame, then reset, then a clean frame
        for (int i = 0; i < 9; i++)
            beat_ab(1'b1, 8'((i / 5) * 16 + (i % 5)));
        do_reset();
        n_win = 0;
        n_fd  = 0;
        frame_ab(1'b0);
        chk("s4_windows", 144'(n_win), 144'd6);

        // Two frames back to back
        n_win = 0;
        n_fd  = 0;
        frame_ab(1'b0);
        frame_ab(1'b0);
        chk("s5_windows", 144'(n_win), 144'd12);
        chk("s5_frame_done", 144'(n_fd), 144'd2);

        // KERNEL=1 pass-through
        @(negedge clk);
        en_ab = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            en_c  = ktab[i].en;
            pix_c = ktab[i].pix;
            @(posedge clk);
            #1;
            chk($sformatf("k1_en_out[%0d]", i), 144'(eo_c), 144'(ktab[i].exp_en));
            chk($sformatf("k1_data[%0d]", i), 144'(d_c), 144'(ktab[i].exp_d));
            chk($sformatf("k1_frame_done[%0d]", i), 144'(fd_c), 144'(ktab[i].exp_fd));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
